// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter with a small byte FIFO in front.
// Bytes written through the valid/ready port are queued and shifted out
// LSB first with one start and one stop bit. Frames queued back to back
// leave the line with no idle gap between a stop bit and the next start bit.
module uart_tx #(
  parameter int CLKS_PER_BIT = 52,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    data_in,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    fifoMem [FIFO_DEPTH];
  logic [PW-1:0] wrPtr_q, rdPtr_q;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  state_t        state_q, state_d;
  logic [TW-1:0] bitTimer_q, bitTimer_d;
  logic [2:0]    bitIdx_q, bitIdx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          lastTick;
  logic [7:0]    fifoHead;

  // Readiness depends only on the registered count, so a pop on the same
  // edge can never open room for a write while the FIFO is full.
  assign in_ready   = (count_q != COUNT_FULL);
  assign push       = in_valid && in_ready;
  assign fifo_count = count_q;
  assign tx         = tx_q;
  assign busy       = (state_q != IDLE);
  assign lastTick   = (bitTimer_q == TIMER_LAST);
  assign fifoHead   = fifoMem[rdPtr_q];

  // FIFO storage; stale entries are harmless because reset clears the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifoMem[wrPtr_q] <= data_in;
    end
  end

  // Occupancy follows push and pop together, so a simultaneous pair leaves it unchanged.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  // FIFO pointers and count; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + PW'(1);
      if (pop)  rdPtr_q <= rdPtr_q + PW'(1);
      count_q <= count_d;
    end
  end

  // Frame sequencing: the line value for the next bit period is decided on
  // the edge that ends the current one, so tx stays a clean register output.
  always_comb begin
    state_d    = state_q;
    bitTimer_d = bitTimer_q;
    bitIdx_d   = bitIdx_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d       = 1'b1;
        bitTimer_d = '0;
        bitIdx_d   = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = fifoHead;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (lastTick) begin
          bitTimer_d = '0;
          bitIdx_d   = '0;
          tx_d       = shift_q[0];
          shift_d    = {1'b0, shift_q[7:1]};
          state_d    = DATA;
        end else begin
          bitTimer_d = bitTimer_q + TW'(1);
        end
      end
      DATA: begin
        if (lastTick) begin
          bitTimer_d = '0;
          if (bitIdx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
            tx_d     = shift_q[0];
            shift_d  = {1'b0, shift_q[7:1]};
          end
        end else begin
          bitTimer_d = bitTimer_q + TW'(1);
        end
      end
      STOP: begin
        if (lastTick) begin
          bitTimer_d = '0;
          bitIdx_d   = '0;
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = fifoHead;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          bitTimer_d = bitTimer_q + TW'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // Transmitter state register; reset drops any frame in flight and idles the line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bitTimer_q <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      bitTimer_q <= bitTimer_d;
      bitIdx_q   <= bitIdx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
    end
  end

endmodule
